// File: rtl/ewrapper_link_rxi.sv
// eLink receive decoder: rebuilds emesh transactions (including header-less
// burst beats) from the 72-bit deserializer word and queues them to a master port.
module ewrapper_link_rxi #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        txo_lclk,
  input  logic        reset,
  input  logic [71:0] rx_out,
  input  logic        rxo_emesh_wait,
  input  logic        err_clr,
  output logic        rxo_emesh_access,
  output logic        rxo_emesh_write,
  output logic [1:0]  rxo_emesh_datamode,
  output logic [3:0]  rxo_emesh_ctrlmode,
  output logic [31:0] rxo_emesh_dstaddr,
  output logic [31:0] rxo_emesh_srcaddr,
  output logic [31:0] rxo_emesh_data,
  output logic        rx_frame_err,
  output logic        rx_overflow
);

  localparam logic [7:0] FRAME_IDLE = 8'h00;
  localparam logic [7:0] FRAME_HDR  = 8'h3F;
  localparam logic [7:0] FRAME_DATA = 8'hFF;

  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, BURST} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } txn_t;

  // ---------------------------------------------------------------- input stage
  logic [71:0] rx_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) rx_q <= '0;
    else       rx_q <= rx_out;
  end

  logic [7:0]  frame;
  logic [63:0] d;

  assign frame = rx_q[71:64];

  // Channel c carries bit k of every byte lane: a bit transpose.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // infer a latch.
    d = '0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 8; c++) begin
        d[8*k+c] = rx_q[8*c+k];
      end
    end
  end

  logic hdr_valid;
  logic unused_hdr_bits;

  assign hdr_valid       = d[0] & (d[47] == ~d[1]);
  assign unused_hdr_bits = ^{d[46:43], d[41:40]};

  // ---------------------------------------------------------------- decoder FSM
  state_t state_q, state_d;
  logic   latch_hdr, push, err_set;

  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (frame)
      FRAME_IDLE: state_d = IDLE;
      FRAME_HDR:  state_d = hdr_valid ? HDR : IDLE;
      FRAME_DATA: state_d = (state_q == IDLE) ? IDLE : BURST;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    latch_hdr = 1'b0;
    push      = 1'b0;
    err_set   = 1'b0;
    case (frame)
      FRAME_IDLE: err_set = (state_q == HDR);
      FRAME_HDR: begin
        latch_hdr = hdr_valid;
        err_set   = ~hdr_valid | (state_q == HDR);
      end
      FRAME_DATA: begin
        push    = (state_q != IDLE);
        err_set = (state_q == IDLE);
      end
      default: err_set = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- header stage
  logic        hdr_write_q;
  logic [1:0]  hdr_dm_q;
  logic [3:0]  hdr_ctrl_q;
  logic        hdr_inc0_q;
  logic [31:0] dst_q;

  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) begin
      hdr_write_q <= 1'b0;
      hdr_dm_q    <= '0;
      hdr_ctrl_q  <= '0;
      hdr_inc0_q  <= 1'b0;
      dst_q       <= '0;
    end else if (latch_hdr) begin
      hdr_write_q <= d[1];
      hdr_dm_q    <= d[3:2];
      hdr_ctrl_q  <= d[39:36];
      hdr_inc0_q  <= d[42];
      dst_q       <= d[35:4];
    end else if (push) begin
      dst_q <= dst_q + (hdr_inc0_q ? 32'd0 : 32'd8);
    end
  end

  txn_t push_txn;

  assign push_txn = '{write:    hdr_write_q,
                      datamode: hdr_dm_q,
                      ctrlmode: hdr_ctrl_q,
                      dstaddr:  dst_q,
                      srcaddr:  d[31:0],
                      data:     d[63:32]};

  // ---------------------------------------------------------------- FIFO
  txn_t               mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               fifo_empty, fifo_full, load, pop, push_ok, drop;
  txn_t               out_q;
  logic               access_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign load       = ~access_q | ~rxo_emesh_wait;
  assign pop        = load & ~fifo_empty;
  assign push_ok    = push & (~fifo_full | pop);
  assign drop       = push & fifo_full & ~pop;

  // NOTE: storage is not reset; the pointers and count alone define which
  // entries are live, so reset discards contents without clearing the array.
  always_ff @(posedge txo_lclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_txn;
  end

  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- output register
  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      access_q <= 1'b0;
    end else if (load) begin
      access_q <= ~fifo_empty;
      if (!fifo_empty) out_q <= mem_q[rd_ptr_q];
    end
  end

  assign rxo_emesh_access   = access_q;
  assign rxo_emesh_write    = out_q.write;
  assign rxo_emesh_datamode = out_q.datamode;
  assign rxo_emesh_ctrlmode = out_q.ctrlmode;
  assign rxo_emesh_dstaddr  = out_q.dstaddr;
  assign rxo_emesh_srcaddr  = out_q.srcaddr;
  assign rxo_emesh_data     = out_q.data;

  // ---------------------------------------------------------------- sticky flags
  logic frame_err_q, overflow_q;

  // A new error in the same cycle as err_clr wins.
  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= (frame_err_q & ~err_clr) | err_set;
      overflow_q  <= (overflow_q & ~err_clr) | drop;
    end
  end

  assign rx_frame_err = frame_err_q;
  assign rx_overflow  = overflow_q;

endmodule

// File: tb/tb_ewrapper_link_rxi.sv
// Directed bench for ewrapper_link_rxi: per-cycle vector table plus
// hand-written backpressure and mid-burst reset sequences.
module tb_ewrapper_link_rxi;

  logic        txo_lclk = 1'b0;
  logic        reset;
  logic [71:0] rx_out;
  logic        rxo_emesh_wait;
  logic        err_clr;
  logic        rxo_emesh_access;
  logic        rxo_emesh_write;
  logic [1:0]  rxo_emesh_datamode;
  logic [3:0]  rxo_emesh_ctrlmode;
  logic [31:0] rxo_emesh_dstaddr;
  logic [31:0] rxo_emesh_srcaddr;
  logic [31:0] rxo_emesh_data;
  logic        rx_frame_err;
  logic        rx_overflow;

  ewrapper_link_rxi #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .txo_lclk           (txo_lclk),
    .reset              (reset),
    .rx_out             (rx_out),
    .rxo_emesh_wait     (rxo_emesh_wait),
    .err_clr            (err_clr),
    .rxo_emesh_access   (rxo_emesh_access),
    .rxo_emesh_write    (rxo_emesh_write),
    .rxo_emesh_datamode (rxo_emesh_datamode),
    .rxo_emesh_ctrlmode (rxo_emesh_ctrlmode),
    .rxo_emesh_dstaddr  (rxo_emesh_dstaddr),
    .rxo_emesh_srcaddr  (rxo_emesh_srcaddr),
    .rxo_emesh_data     (rxo_emesh_data),
    .rx_frame_err       (rx_frame_err),
    .rx_overflow        (rx_overflow)
  );

  initial forever #5 txo_lclk = ~txo_lclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inverse of the channel transpose: data bit 8k+c rides channel c, bit k.
  function automatic logic [71:0] pack(input logic [7:0] f, input logic [63:0] dv);
    logic [71:0] r;
    r[71:64] = f;
    r[63:0]  = '0;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++)
        r[8*c+k] = dv[8*k+c];
    return r;
  endfunction

  function automatic logic [63:0] hdr(input logic wr, input logic [1:0] dm, input logic [3:0] ctrl,
                                      input logic [31:0] dst, input logic inc0, input logic bad);
    logic [63:0] h;
    h        = '0;
    h[0]     = 1'b1;
    h[1]     = wr;
    h[3:2]   = dm;
    h[35:4]  = dst;
    h[39:36] = ctrl;
    h[42]    = inc0;
    h[47]    = bad ? wr : ~wr;
    return h;
  endfunction

  function automatic logic [63:0] dbeat(input logic [31:0] src, input logic [31:0] dat);
    return {dat, src};
  endfunction

  typedef struct {
    logic [7:0]  frame;
    logic [63:0] d;
    logic        clr;
    logic        eerr;
    logic        eacc;
    logic        ewr;
    logic [1:0]  edm;
    logic [3:0]  ectrl;
    logic [31:0] edst;
    logic [31:0] esrc;
    logic [31:0] edata;
  } vec_t;

  function automatic vec_t v_in(input logic [7:0] f, input logic [63:0] dv, input logic clr, input logic eerr);
    vec_t v;
    v.frame = f;   v.d = dv;     v.clr = clr;  v.eerr = eerr;
    v.eacc  = 1'b0; v.ewr = 1'b0; v.edm = '0;   v.ectrl = '0;
    v.edst  = '0;  v.esrc = '0;  v.edata = '0;
    return v;
  endfunction

  function automatic vec_t v_tx(input logic [7:0] f, input logic [63:0] dv,
                                input logic wr, input logic [1:0] dm, input logic [3:0] ctrl,
                                input logic [31:0] dst, input logic [31:0] src, input logic [31:0] dat);
    vec_t v;
    v       = v_in(f, dv, 1'b0, 1'b0);
    v.eacc  = 1'b1;
    v.ewr   = wr;   v.edm  = dm;  v.ectrl = ctrl;
    v.edst  = dst;  v.esrc = src; v.edata = dat;
    return v;
  endfunction

  task automatic step();
    @(posedge txo_lclk);
    #1;
  endtask

  vec_t tbl[$];
  int   got;

  initial begin
    reset          = 1'b1;
    rx_out         = '0;
    rxo_emesh_wait = 1'b0;
    err_clr        = 1'b0;

    #1;
    check("rst.access", rxo_emesh_access, 0);
    check("rst.dst",    rxo_emesh_dstaddr, 0);
    check("rst.data",   rxo_emesh_data, 0);
    check("rst.err",    rx_frame_err, 0);
    check("rst.ovf",    rx_overflow, 0);
    step(); step();
    reset = 1'b0;
    step();

    // Single write: FF beat lands on the outputs two edges after its own edge.
    tbl.push_back(v_in(8'h3F, hdr(1, 2'd2, 4'h0, 32'h8000_0010, 0, 0), 0, 0));
    tbl.push_back(v_in(8'hFF, dbeat(32'h1234_5678, 32'hDEAD_BEEF), 0, 0));
    tbl.push_back(v_in(8'h00, '0, 0, 0));
    tbl.push_back(v_tx(8'h00, '0, 1, 2'd2, 4'h0, 32'h8000_0010, 32'h1234_5678, 32'hDEAD_BEEF));
    tbl.push_back(v_in(8'h00, '0, 0, 0));
    // Double-word burst, incrementing addresses.
    tbl.push_back(v_in(8'h3F, hdr(1, 2'd3, 4'h0, 32'h100, 0, 0), 0, 0));
    tbl.push_back(v_in(8'hFF, dbeat(32'hA0, 32'hB0), 0, 0));
    tbl.push_back(v_in(8'hFF, dbeat(32'hA1, 32'hB1), 0, 0));
    tbl.push_back(v_tx(8'hFF, dbeat(32'hA2, 32'hB2), 1, 2'd3, 4'h0, 32'h100, 32'hA0, 32'hB0));
    tbl.push_back(v_tx(8'hFF, dbeat(32'hA3, 32'hB3), 1, 2'd3, 4'h0, 32'h108, 32'hA1, 32'hB1));
    tbl.push_back(v_tx(8'h00, '0, 1, 2'd3, 4'h0, 32'h110, 32'hA2, 32'hB2));
    tbl.push_back(v_tx(8'h00, '0, 1, 2'd3, 4'h0, 32'h118, 32'hA3, 32'hB3));
    tbl.push_back(v_in(8'h00, '0, 0, 0));
    // Same burst with inc0: address is held.
    tbl.push_back(v_in(8'h3F, hdr(1, 2'd3, 4'h0, 32'h100, 1, 0), 0, 0));
    tbl.push_back(v_in(8'hFF, dbeat(32'hC0, 32'hD0), 0, 0));
    tbl.push_back(v_in(8'hFF, dbeat(32'hC1, 32'hD1), 0, 0));
    tbl.push_back(v_tx(8'h00, '0, 1, 2'd3, 4'h0, 32'h100, 32'hC0, 32'hD0));
    tbl.push_back(v_tx(8'h00, '0, 1, 2'd3, 4'h0, 32'h100, 32'hC1, 32'hD1));
    tbl.push_back(v_in(8'h00, '0, 0, 0));
    // Back-to-back single transactions with different headers, no error.
    tbl.push_back(v_in(8'h3F, hdr(0, 2'd1, 4'h5, 32'h2000, 0, 0), 0, 0));
    tbl.push_back(v_in(8'hFF, dbeat(32'h11, 32'h22), 0, 0));
    tbl.push_back(v_in(8'h3F, hdr(1, 2'd0, 4'hA, 32'h3000, 0, 0), 0, 0));
    tbl.push_back(v_tx(8'hFF, dbeat(32'h33, 32'h44), 0, 2'd1, 4'h5, 32'h2000, 32'h11, 32'h22));
    tbl.push_back(v_in(8'h00, '0, 0, 0));
    tbl.push_back(v_tx(8'h00, '0, 1, 2'd0, 4'hA, 32'h3000, 32'h33, 32'h44));
    tbl.push_back(v_in(8'h00, '0, 0, 0));
    // Orphan data beat, then clear.
    tbl.push_back(v_in(8'hFF, dbeat(32'h55, 32'h66), 0, 0));
    tbl.push_back(v_in(8'h00, '0, 0, 1));
    tbl.push_back(v_in(8'h00, '0, 1, 0));
    // Illegal frame byte, then clear.
    tbl.push_back(v_in(8'h0F, '0, 0, 0));
    tbl.push_back(v_in(8'h00, '0, 0, 1));
    tbl.push_back(v_in(8'h00, '0, 1, 0));
    // Header with bad check bit, then clear.
    tbl.push_back(v_in(8'h3F, hdr(1, 2'd2, 4'h0, 32'h40, 0, 1), 0, 0));
    tbl.push_back(v_in(8'h00, '0, 0, 1));
    tbl.push_back(v_in(8'h00, '0, 1, 0));
    // Error coinciding with err_clr keeps the flag set.
    tbl.push_back(v_in(8'hFF, '0, 0, 0));
    tbl.push_back(v_in(8'h00, '0, 1, 1));
    tbl.push_back(v_in(8'h00, '0, 1, 0));
    // Header followed by an idle frame is an error.
    tbl.push_back(v_in(8'h3F, hdr(1, 2'd2, 4'h0, 32'h80, 0, 0), 0, 0));
    tbl.push_back(v_in(8'h00, '0, 0, 0));
    tbl.push_back(v_in(8'h00, '0, 0, 1));
    tbl.push_back(v_in(8'h00, '0, 1, 0));
    // Address wrap at the top of the 32-bit space.
    tbl.push_back(v_in(8'h3F, hdr(1, 2'd3, 4'h0, 32'hFFFF_FFF8, 0, 0), 0, 0));
    tbl.push_back(v_in(8'hFF, dbeat(32'h71, 32'h81), 0, 0));
    tbl.push_back(v_in(8'hFF, dbeat(32'h72, 32'h82), 0, 0));
    tbl.push_back(v_tx(8'h00, '0, 1, 2'd3, 4'h0, 32'hFFFF_FFF8, 32'h71, 32'h81));
    tbl.push_back(v_tx(8'h00, '0, 1, 2'd3, 4'h0, 32'h0000_0000, 32'h72, 32'h82));
    tbl.push_back(v_in(8'h00, '0, 0, 0));

    foreach (tbl[i]) begin
      rx_out  = pack(tbl[i].frame, tbl[i].d);
      err_clr = tbl[i].clr;
      step();
      check($sformatf("v%0d.access", i), rxo_emesh_access, tbl[i].eacc);
      check($sformatf("v%0d.err", i),    rx_frame_err,     tbl[i].eerr);
      check($sformatf("v%0d.ovf", i),    rx_overflow,      0);
      if (tbl[i].eacc) begin
        check($sformatf("v%0d.write", i), rxo_emesh_write,    tbl[i].ewr);
        check($sformatf("v%0d.dm", i),    rxo_emesh_datamode, tbl[i].edm);
        check($sformatf("v%0d.ctrl", i),  rxo_emesh_ctrlmode, tbl[i].ectrl);
        check($sformatf("v%0d.dst", i),   rxo_emesh_dstaddr,  tbl[i].edst);
        check($sformatf("v%0d.src", i),   rxo_emesh_srcaddr,  tbl[i].esrc);
        check($sformatf("v%0d.data", i),  rxo_emesh_data,     tbl[i].edata);
      end
    end
    err_clr = 1'b0;

    // Backpressure: 10-beat burst into an 8-deep FIFO while stalled.
    rxo_emesh_wait = 1'b1;
    rx_out = pack(8'h3F, hdr(1, 2'd3, 4'h0, 32'h400, 0, 0));
    step();
    for (int n = 0; n < 10; n++) begin
      rx_out = pack(8'hFF, dbeat(32'h500 + n, 32'hC00 + n));
      step();
    end
    rx_out = '0;
    for (int n = 0; n < 4; n++) step();
    for (int n = 0; n < 3; n++) begin
      check("bp.frozen.access", rxo_emesh_access, 1);
      check("bp.frozen.dst",    rxo_emesh_dstaddr, 32'h400);
      check("bp.frozen.data",   rxo_emesh_data, 32'hC00);
      step();
    end
    check("bp.overflow", rx_overflow, 1);
    check("bp.err",      rx_frame_err, 0);
    rxo_emesh_wait = 1'b0;
    got = 0;
    for (int n = 0; n < 30; n++) begin
      if (rxo_emesh_access) begin
        check($sformatf("bp.t%0d.dst", got),  rxo_emesh_dstaddr, 32'h400 + 32'(8 * got));
        check($sformatf("bp.t%0d.src", got),  rxo_emesh_srcaddr, 32'h500 + 32'(got));
        check($sformatf("bp.t%0d.data", got), rxo_emesh_data,    32'hC00 + 32'(got));
        got++;
      end
      step();
    end
    check("bp.count", got, 9);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("bp.ovf_clr", rx_overflow, 0);

    // Reset in the middle of a burst.
    rx_out = pack(8'h3F, hdr(1, 2'd0, 4'h0, 32'h600, 0, 0));
    step();
    rx_out = pack(8'hFF, dbeat(32'h1, 32'h2));
    step();
    rx_out = pack(8'hFF, dbeat(32'h3, 32'h4));
    step();
    rx_out = '0;
    step();
    check("mid.access", rxo_emesh_access, 1);
    check("mid.dst",    rxo_emesh_dstaddr, 32'h600);
    #2 reset = 1'b1;
    #1;
    check("rst2.access", rxo_emesh_access, 0);
    check("rst2.dst",    rxo_emesh_dstaddr, 0);
    check("rst2.data",   rxo_emesh_data, 0);
    step();
    reset = 1'b0;
    got = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (rxo_emesh_access) got++;
    end
    check("rst2.fifo_flushed", got, 0);
    rx_out = pack(8'hFF, dbeat(32'h9, 32'h9));
    step();
    rx_out = '0;
    step();
    check("rst2.orphan_err", rx_frame_err, 1);
    check("rst2.no_access",  rxo_emesh_access, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
